// File: rtl/ysyx_23060240_idu.sv
// RV32I decode stage: one-entry valid/ready output register holding the decoded instruction.
// Optional YSYX_RV32E_EN restricts register indices to x0..x15; the default build accepts all 32.
module ysyx_23060240_idu #(
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_inst,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2,
   output logic [4:0]  out_rd,
   output logic [31:0] out_imm,
   output logic [3:0]  out_opclass,
   output logic        out_rd_wen,
   output logic        out_illegal
);

   typedef struct packed {
      logic [3:0]  opclass;
      logic [31:0] imm;
      logic        rd_wen;
      logic        illegal;
   } dec_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   function automatic dec_t decode(input logic [31:0] inst);
      dec_t        d;
      logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
      logic        writes;
      imm_i = {{20{inst[31]}}, inst[31:20]};
      imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      imm_u = {inst[31:12], 12'b0};
      imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      d.opclass = 4'd15;
      d.imm     = 32'd0;
      d.illegal = 1'b0;
      writes    = 1'b1;
      case (inst[6:0])
         OPC_LUI:    begin d.opclass = 4'd0; d.imm = imm_u; end
         OPC_AUIPC:  begin d.opclass = 4'd1; d.imm = imm_u; end
         OPC_JAL:    begin d.opclass = 4'd2; d.imm = imm_j; end
         OPC_JALR:   begin d.opclass = 4'd3; d.imm = imm_i; end
         OPC_BRANCH: begin d.opclass = 4'd4; d.imm = imm_b; writes = 1'b0; end
         OPC_LOAD:   begin d.opclass = 4'd5; d.imm = imm_i; end
         OPC_STORE:  begin d.opclass = 4'd6; d.imm = imm_s; writes = 1'b0; end
         OPC_OPIMM:  begin d.opclass = 4'd7; d.imm = imm_i; end
         OPC_OP:     begin d.opclass = 4'd8; d.imm = 32'd0; end
         OPC_SYSTEM: begin d.opclass = 4'd9; d.imm = imm_i; end
         default:    d.illegal = 1'b1;
      endcase
`ifdef YSYX_RV32E_EN
      begin
         logic use_rs1, use_rs2, use_rd;
         use_rs1 = 1'b0;
         use_rs2 = 1'b0;
         use_rd  = 1'b0;
         case (d.opclass)
            4'd8:                   begin use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
            4'd3, 4'd5, 4'd7, 4'd9: begin use_rs1 = 1'b1; use_rd = 1'b1; end
            4'd4, 4'd6:             begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            4'd0, 4'd1, 4'd2:       use_rd = 1'b1;
            default:                ;
         endcase
         if ((use_rs1 && inst[19]) || (use_rs2 && inst[24]) || (use_rd && inst[11]))
            d.illegal = 1'b1;
      end
`endif
      if (d.illegal) begin
         d.opclass = 4'd15;
         d.imm     = 32'd0;
      end
      d.rd_wen = writes && !d.illegal && (inst[11:7] != 5'd0);
      return d;
   endfunction

   logic        valid_reg;
   logic [31:0] pc_reg;
   logic [31:0] inst_reg;
   dec_t        dec_reg;
   dec_t        dec_next;
   logic        accept;

   assign in_ready = !valid_reg || out_ready;
   assign accept   = in_valid && in_ready && !flush;
   assign dec_next = decode(in_inst);

   // Flush outranks both accept and consume; data fields only change on accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_reg <= 1'b0;
         pc_reg    <= 32'h80000000;
         inst_reg  <= NOP_INST;
         dec_reg   <= decode(NOP_INST);
      end else if (flush) begin
         valid_reg <= 1'b0;
      end else if (accept) begin
         valid_reg <= 1'b1;
         pc_reg    <= in_pc;
         inst_reg  <= in_inst;
         dec_reg   <= dec_next;
      end else if (out_ready) begin
         valid_reg <= 1'b0;
      end
   end

   assign out_valid   = valid_reg;
   assign out_pc      = pc_reg;
   assign out_inst    = inst_reg;
   assign out_rs1     = inst_reg[19:15];
   assign out_rs2     = inst_reg[24:20];
   assign out_rd      = inst_reg[11:7];
   assign out_imm     = dec_reg.imm;
   assign out_opclass = dec_reg.opclass;
   assign out_rd_wen  = dec_reg.rd_wen;
   assign out_illegal = dec_reg.illegal;

endmodule

// File: doc/ysyx_23060240_idu.md
YSYX_23060240_IDU -- requirements
Module: ysyx_23060240_IDU

Interface
REQ-001 SHALL have parameter NOP_INST, default 32'h00000013; instruction word whose decode drives the output register after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  fetch unit presents pc/inst.
REQ-005 SHALL have port in_ready  output  1  this stage accepts on this cycle.
REQ-006 SHALL have port in_pc  input  32  pc of the presented instruction.
REQ-007 SHALL have port in_inst  input  32  instruction word.
REQ-008 SHALL have port flush  input  1  redirect: discard the held instruction.
REQ-009 SHALL have port out_valid  output  1  decoded instruction valid for the execute stage.
REQ-010 SHALL have port out_ready  input  1  execute stage consumes on this cycle.
REQ-011 SHALL have ports out_pc  output  32 and out_inst  output  32, registered copies of the input.
REQ-012 SHALL have ports out_rs1, out_rs2, out_rd  output  5 each; inst[19:15], [24:20], [11:7].
REQ-013 SHALL have port out_imm  output  32  sign-extended immediate.
REQ-014 SHALL have port out_opclass  output  4  instruction class code.
REQ-015 SHALL have ports out_rd_wen  output  1 and out_illegal  output  1.

Function
REQ-016 SHALL hold two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 SHALL drive in_ready = EMPTY or out_ready, combinationally; in_ready SHALL NOT depend on in_valid.
REQ-018 SHALL accept on in_valid&&in_ready&&!flush, latching the decode of in_inst/in_pc into the output register; out_* valid the next cycle (latency 1) and state goes FULL.
REQ-019 SHALL go EMPTY after out_valid&&out_ready without a simultaneous accept; with a simultaneous accept it SHALL stay FULL with the new instruction (back-to-back, no bubble).
REQ-020 SHALL, when FULL and out_ready=0, hold every out_* stable and drop nothing.
REQ-021 SHALL, on flush, go EMPTY next cycle and discard any same-cycle accept; flush has priority over accept and consume.
REQ-022 SHALL encode out_opclass: LUI=0, AUIPC=1, JAL=2, JALR=3, BRANCH=4, LOAD=5, STORE=6, OP-IMM=7, OP=8, SYSTEM=9, illegal=15.
REQ-023 SHALL select out_imm by format: I (LOAD, OP-IMM, JALR, SYSTEM), S, B, U, J per RV32I; bit 31 of inst is the sign; OP yields 0.
REQ-024 SHALL assert out_illegal when inst[1:0]!=2'b11 or opcode is unlisted; then out_opclass=15, out_rd_wen=0.
REQ-025 SHALL assert out_rd_wen for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, SYSTEM only when rd!=0.

Reset
REQ-026 SHALL, while rst=0, force state EMPTY, out_valid=0, out_pc=32'h80000000, and out_inst with all decode fields equal to the decode of NOP_INST (opclass 7, rd 0, rd_wen 0, imm 0, illegal 0).
REQ-027 SHALL take effect asynchronously mid-transfer; the first accept is possible on the first rising edge after rst rises.

Configuration
REQ-028 SHALL, with YSYX_RV32E_EN defined, flag out_illegal (opclass 15, rd_wen 0) when any register index used by the format has bit 4 set.
REQ-029 SHALL, without YSYX_RV32E_EN, accept all 32 register indices and never flag on index value.

Verification
REQ-030 SHALL cover: in_inst=32'h00500093, pc=32'h80000000 accepted, out_ready=1 -> next cycle out_valid=1, opclass 7, rd=1, rs1=0, imm=5, rd_wen=1.
REQ-031 SHALL cover: in_inst=32'hFFDFF0EF (jal x1,-4) -> opclass 2, rd=1, imm=32'hFFFFFFFC, rd_wen=1.
REQ-032 SHALL cover: FULL, out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* unchanged; out_ready=1 -> new instruction next cycle, no bubble.
REQ-033 SHALL cover: FULL with flush=1 and in_valid=1 same cycle -> out_valid=0 next cycle, new instruction not held.
REQ-034 SHALL cover: in_inst=32'h00000833 (add x16,x0,x0) -> with YSYX_RV32E_EN out_illegal=1, opclass 15; without it opclass 8, rd=16, rd_wen=1.
REQ-035 SHALL cover: rst dropped to 0 while FULL -> out_valid=0 immediately, out_pc=32'h80000000.
